// File: rtl/mmio_periph_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mmio_periph_bank : LED / debounced switch / hex display / compare timer bank
// on the picorv32 native bus, with its own wait-state ready.  Rev 1.0
// ----------------------------------------------------------------------------
module mmio_periph_bank #(
   parameter logic [31:0] BASE_ADDR       = 32'h0000_8000,
   parameter int          LED_W           = 8,
   parameter int          SW_W            = 8,
   parameter int          HEX_DIGITS      = 6,
   parameter int          WAIT_STATES     = 0,
   parameter int          DEBOUNCE_CYCLES = 16
) (
   input  logic                    sys_clk,
   input  logic                    sys_resetn,
   input  logic                    mem_valid,
   input  logic [31:0]             mem_addr,
   input  logic [31:0]             mem_wdata,
   input  logic [3:0]              mem_wstrb,
   output logic                    mem_ready,
   output logic [31:0]             mem_rdata,
   output logic                    periph_sel,
   output logic [LED_W-1:0]        LEDR,
   input  logic [SW_W-1:0]         SW,
   output logic [4*HEX_DIGITS-1:0] hex_data,
   output logic [HEX_DIGITS-1:0]   hex_blank,
   output logic                    irq
);

   localparam int HEX_W  = 4 * HEX_DIGITS;
   localparam int WCNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
   localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   localparam logic [3:0] OFF_LED    = 4'h0;
   localparam logic [3:0] OFF_SW     = 4'h1;
   localparam logic [3:0] OFF_HEX    = 4'h4;
   localparam logic [3:0] OFF_BLANK  = 4'h5;
   localparam logic [3:0] OFF_TCOUNT = 4'h8;
   localparam logic [3:0] OFF_TCMP   = 4'h9;
   localparam logic [3:0] OFF_TCTRL  = 4'hA;
   localparam logic [3:0] OFF_TSTAT  = 4'hB;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2} state_t;

   state_t              state_q;
   logic [WCNT_W-1:0]   wcnt_q;
   logic                mem_ready_q;
   logic [31:0]         rdata_q;

   logic [LED_W-1:0]    led_q,    led_d;
   logic [HEX_W-1:0]    hex_q,    hex_d;
   logic [HEX_DIGITS-1:0] blank_q, blank_d;
   logic [31:0]         tcount_q, tcount_d;
   logic [31:0]         tcmp_q,   tcmp_d;
   logic [2:0]          ctrl_q,   ctrl_d;
   logic                flag_q,   flag_d;
   logic                irq_q;

   logic [SW_W-1:0]     sync1_q, sync2_q, swreg_q;
   logic [DB_W-1:0]     dbcnt_q;

   logic [3:0]          w_idx;
   logic                w_wr;
   logic                w_match;
   logic [31:0]         w_rd_mux;
   logic [31:0]         w_merge;
   logic                unused_ok;

   assign periph_sel = mem_valid && (mem_addr[31:6] == BASE_ADDR[31:6]);
   assign w_idx      = mem_addr[5:2];
   assign w_wr       = (state_q == S_ACK) && periph_sel && (mem_wstrb != 4'b0000);
   assign unused_ok  = ^mem_addr[1:0];

   function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) begin
         r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return r;
   endfunction

   always_comb begin
      w_rd_mux = 32'd0;
      case (w_idx)
         OFF_LED:    w_rd_mux = 32'(led_q);
         OFF_SW:     w_rd_mux = 32'(swreg_q);
         OFF_HEX:    w_rd_mux = 32'(hex_q);
         OFF_BLANK:  w_rd_mux = 32'(blank_q);
         OFF_TCOUNT: w_rd_mux = tcount_q;
         OFF_TCMP:   w_rd_mux = tcmp_q;
         OFF_TCTRL:  w_rd_mux = {29'd0, ctrl_q};
         OFF_TSTAT:  w_rd_mux = {31'd0, flag_q};
         default:    w_rd_mux = 32'd0;
      endcase
   end

   // Strobed lanes replace the addressed register's current (zero-extended) value.
   assign w_merge = lane_merge(w_rd_mux, mem_wdata, mem_wstrb);

   always_ff @(posedge sys_clk or negedge sys_resetn) begin
      if (!sys_resetn) begin
         state_q     <= S_IDLE;
         wcnt_q      <= '0;
         mem_ready_q <= 1'b0;
         rdata_q     <= 32'd0;
      end else begin
         mem_ready_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (periph_sel) begin
                  wcnt_q <= '0;
                  if (WAIT_STATES == 0) begin
                     state_q     <= S_ACK;
                     mem_ready_q <= 1'b1;
                     rdata_q     <= w_rd_mux;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (!periph_sel) begin
                  state_q <= S_IDLE;
               end else if (wcnt_q == WCNT_W'(WAIT_STATES - 1)) begin
                  state_q     <= S_ACK;
                  mem_ready_q <= 1'b1;
                  rdata_q     <= w_rd_mux;
               end else begin
                  wcnt_q <= wcnt_q + 1'b1;
               end
            end
            S_ACK:   state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      led_d    = led_q;
      hex_d    = hex_q;
      blank_d  = blank_q;
      tcmp_d   = tcmp_q;
      ctrl_d   = ctrl_q;
      flag_d   = flag_q;
      tcount_d = tcount_q;
      w_match  = ctrl_q[0] && (tcount_q == tcmp_q);

      if (ctrl_q[0]) begin
         tcount_d = (w_match && ctrl_q[2]) ? 32'd0 : tcount_q + 32'd1;
      end

      if (w_wr) begin
         case (w_idx)
            OFF_LED:    led_d    = w_merge[LED_W-1:0];
            OFF_HEX:    hex_d    = w_merge[HEX_W-1:0];
            OFF_BLANK:  blank_d  = w_merge[HEX_DIGITS-1:0];
            OFF_TCOUNT: tcount_d = w_merge;
            OFF_TCMP:   tcmp_d   = w_merge;
            OFF_TCTRL:  ctrl_d   = w_merge[2:0];
            OFF_TSTAT:  if (mem_wstrb[0] && mem_wdata[0]) flag_d = 1'b0;
            default:    ;
         endcase
      end

      // A match in the same cycle as a clear keeps the flag set.
      if (w_match) begin
         flag_d = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_resetn) begin
      if (!sys_resetn) begin
         led_q    <= '0;
         hex_q    <= '0;
         blank_q  <= '0;
         tcount_q <= 32'd0;
         tcmp_q   <= 32'd0;
         ctrl_q   <= 3'd0;
         flag_q   <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         led_q    <= led_d;
         hex_q    <= hex_d;
         blank_q  <= blank_d;
         tcount_q <= tcount_d;
         tcmp_q   <= tcmp_d;
         ctrl_q   <= ctrl_d;
         flag_q   <= flag_d;
         irq_q    <= flag_d & ctrl_d[1];
      end
   end

   // The counter restarts on the edge where the synchronised value changes.
   always_ff @(posedge sys_clk or negedge sys_resetn) begin
      if (!sys_resetn) begin
         sync1_q <= '0;
         sync2_q <= '0;
         swreg_q <= '0;
         dbcnt_q <= '0;
      end else begin
         sync1_q <= SW;
         sync2_q <= sync1_q;
         if (sync1_q != sync2_q) begin
            dbcnt_q <= '0;
         end else if (dbcnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            swreg_q <= sync2_q;
         end else begin
            dbcnt_q <= dbcnt_q + 1'b1;
         end
      end
   end

   assign mem_ready = mem_ready_q;
   assign mem_rdata = rdata_q;
   assign LEDR      = led_q;
   assign hex_data  = hex_q;
   assign hex_blank = blank_q;
   assign irq       = irq_q;

endmodule
`default_nettype wire
